mouse_quad_emu: RTL and testbench
=================================

# mouse_quad_emu

Parametrised trackball/spinner emulator that converts PS/2-style relative mouse packets into per-axis step streams for arcade cores. It generalises the per-core inline trackball logic to N axes and configurable accumulator width, and adds symmetric saturation, a step-rate divider, a hold input, proper two's-complement flip, and a selectable output mode (direction+clock or Gray-coded quadrature). It sits in the emu top level between `hps_io` (`ps2_mouse`) and the game core's trackball inputs.

## Interface
- `AXES`, default 2: number of independent axes.
- `ACC_W`, default 12: signed accumulator width per axis (≥10).
- `DIV`, default 1: the step tick fires every DIV `clk_sys` cycles (≥1).
- `MODE`, default 0: 0 = direction+clock, 1 = quadrature A/B.
- `clk_sys`  in  1: system clock.
- `reset_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `pkt_toggle_i`  in  1: packet strobe (`ps2_mouse[24]`). Either edge marks a new packet.
- `delta_i`  in  9*AXES: per-axis 9-bit two's-complement delta {sign, byte}. Axis k occupies [9k+8:9k].
- `flip_i`  in  1: when 1, every delta is negated before accumulation.
- `hold_i`  in  1: when 1, stepping is suspended. Accumulation continues.
- `phase_o`  out  2*AXES: axis k occupies [2k+1:2k]. In MODE 0: {dir, clk}. In MODE 1: {A, B}.
- `busy_o`  out  AXES: axis accumulator is non-zero.

## Operation
- Packet detect: `tog_q` is a register of `pkt_toggle_i`. `pkt = pkt_toggle_i ^ tog_q`. There is no double-count on a level held for many cycles.
- Delta: sign-extend the 9-bit value to ACC_W+1 bits. If `flip_i`, use the two's-complement negation (-256 becomes +256).
- Divider: counter `div_q` of width max(1, clog2(DIV)). `tick` is asserted when `div_q == DIV-1`, and the counter then wraps to 0. With DIV=1, `tick` is constantly 1. The divider free-runs regardless of `hold_i`.
- Step: `s = tick & ~hold_i & (acc != 0)`. The step direction `d` is +1 if acc > 0 and -1 if acc < 0.
- Accumulator update: `acc_next = sat(acc + (pkt ? delta : 0) - (s ? d : 0))`.
  - The sum is computed at ACC_W+2 bits.
  - It is clamped to ±(2^(ACC_W-1)-1), which is symmetric; the most-negative code is never stored.
- Simultaneous packet and step: both apply in the same cycle. The step direction comes from the pre-update acc.
- MODE 0 output:
  - On each step, `dir` is set to 1 for d=+1 and 0 for d=-1, and `clk` toggles.
  - When idle, `dir` holds its last value.
- MODE 1 output:
  - Positive steps advance {A,B} 00→01→11→10→00.
  - Negative steps reverse that order.
  - Exactly one bit changes per step.
- `busy_o[k] = (acc_k != 0)`, driven combinationally from the register.

## Timing
- Reset values:
  - acc = 0, `phase_o` = 0, `busy_o` = 0, `div_q` = 0.
  - `tog_q` is cleared to 0. A `pkt_toggle_i` that is already high at reset release therefore counts as one packet on the first edge (intended; the mouse driver resends).
- Latency from packet to acc: a `delta_i` sampled on the clock edge where `pkt` = 1 is visible in acc and `busy_o` after that edge.
- First step: the first `phase_o` change happens on the first subsequent `tick` edge, at the earliest 1 cycle after the packet edge.
- Step rate: at most one step per axis per tick, so one step every DIV cycles.
- Axes are fully independent and step in the same cycle.
- `delta_i` and `flip_i` need only be valid in the cycle where `pkt` = 1.
- Asserting `reset_n` low mid-stream clears everything immediately. The output may glitch to 0; the core tolerates this.

## Structure
- Package `mouse_quad_pkg`:
  - `MODE_DIRCLK = 0`, `MODE_QUAD = 1`.
  - typedef `quad_t` (2-bit phase).
  - function `quad_next(quad_t, logic dir)`.
- Sub-module `mouse_quad_axis`, instantiated AXES times via generate. It holds acc, saturation, step and phase logic for one axis.
- Top level holds `tog_q`, the shared divider, and flip/packet fan-out.

## Test plan
- DIV=1, MODE 0: packet with axis0 delta = +5 → exactly 5 `clk` toggles on consecutive cycles, `dir` = 1, `busy_o[0]` falls after the 5th step.
- Flip: delta = 9'h100 (-256) with `flip_i` = 1 → 256 steps, `dir` = 1. Delta = -3 with `flip_i` = 0 → 3 steps, `dir` = 0, `dir` held after.
- Saturation, ACC_W=10: 3 packets of +255 back-to-back with `hold_i` = 1 → acc = 511 (not 765). Releasing hold gives 511 steps.
- MODE 1, DIV=4: delta = +2 then -2 → phase 00→01→11 at tick spacing of 4 cycles, then 11→01→00.
- Simultaneous events: acc = +3 with a packet of -10 on a tick cycle → acc = -8 next cycle. That cycle's step is positive, then the following steps are negative.
- Reset mid-stream: pull `reset_n` low while acc = 40 → `phase_o` = 0, `busy_o` = 0, no steps after release until a new packet arrives.

Source files
------------

// File: rtl/mouse_quad_pkg.sv
// Shared types and helpers for the mouse-to-trackball step emulator.
// Latency: none (declarations and a pure combinational function only).
// Backpressure: none; the emulator has no flow control, packets are never refused.
package mouse_quad_pkg;

    localparam int MODE_DIRCLK = 0;
    localparam int MODE_QUAD   = 1;

    typedef logic [1:0] quad_t;

    // Gray sequence 00->01->11->10->00 for dir=1, reversed for dir=0.
    function automatic quad_t quad_next(input quad_t q, input logic dir);
        quad_t n;
        case (q)
            2'b00:   n = dir ? 2'b01 : 2'b10;
            2'b01:   n = dir ? 2'b11 : 2'b00;
            2'b11:   n = dir ? 2'b10 : 2'b01;
            default: n = dir ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mouse_quad_axis.sv
// One axis: saturating signed accumulator that drains one count per tick into a phase output.
// Latency: packet visible in acc/busy one edge after pkt; first step on the next tick edge.
// Backpressure: none; hold suspends draining while accumulation continues, clamped symmetrically.
module mouse_quad_axis
    import mouse_quad_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int MODE  = 0
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       pkt,
    input  logic       flip,
    input  logic       tick,
    input  logic       hold,
    input  logic [8:0] delta,
    output logic [1:0] phase,
    output logic       busy
);

    localparam int MAX_I = (1 << (ACC_W - 1)) - 1;
    localparam logic signed [ACC_W+1:0] MAX_V = MAX_I[ACC_W+1:0];
    localparam logic signed [ACC_W+1:0] MIN_V = -MAX_V;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    quad_t                   phase_q;
    logic                    nz;
    logic                    pos;
    logic                    step;
    logic signed [ACC_W+1:0] acc_ext;
    logic signed [ACC_W+1:0] dlt_raw;
    logic signed [ACC_W+1:0] dlt_ext;
    logic signed [ACC_W+1:0] stp_ext;
    logic signed [ACC_W+1:0] sum;

    assign nz   = |acc_q;
    assign pos  = ~acc_q[ACC_W-1];
    assign step = tick & ~hold & nz;

    // Add the (optionally negated) packet delta, remove this cycle's step, clamp to +/-MAX.
    always_comb begin
        acc_ext = {{2{acc_q[ACC_W-1]}}, acc_q};
        dlt_raw = {{(ACC_W - 7){delta[8]}}, delta};
        dlt_ext = '0;
        if (pkt) begin
            dlt_ext = flip ? -dlt_raw : dlt_raw;
        end
        stp_ext = '0;
        if (step) begin
            stp_ext = pos ? {{(ACC_W + 1){1'b0}}, 1'b1} : '1;
        end
        sum   = acc_ext + dlt_ext - stp_ext;
        acc_d = sum[ACC_W-1:0];
        if (sum > MAX_V) begin
            acc_d = MAX_V[ACC_W-1:0];
        end else if (sum < MIN_V) begin
            acc_d = MIN_V[ACC_W-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Advance the phase output once per step in the direction of the pre-update accumulator.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else if (step) begin
            if (MODE == MODE_QUAD) begin
                phase_q <= quad_next(phase_q, pos);
            end else begin
                phase_q <= {pos, ~phase_q[0]};
            end
        end
    end

    assign phase = phase_q;
    assign busy  = nz;

endmodule

// File: rtl/mouse_quad_emu.sv
// Converts PS/2 relative mouse packets into per-axis trackball step streams.
// Latency: delta lands in the accumulator one edge after the toggle edge; steps on later ticks.
// Backpressure: none; overflow saturates, hold pauses stepping only, divider free-runs.
module mouse_quad_emu
    import mouse_quad_pkg::*;
#(
    parameter int AXES  = 2,
    parameter int ACC_W = 12,
    parameter int DIV   = 1,
    parameter int MODE  = MODE_DIRCLK
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                pkt_toggle_i,
    input  logic [9*AXES-1:0]   delta_i,
    input  logic                flip_i,
    input  logic                hold_i,
    output logic [2*AXES-1:0]   phase_o,
    output logic [AXES-1:0]     busy_o
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic             tog_q;
    logic             pkt;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign pkt  = pkt_toggle_i ^ tog_q;
    assign tick = (div_q == DIV_LAST);

    // Remember the last toggle level so either edge yields exactly one packet pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= pkt_toggle_i;
        end
    end

    // Free-running step-rate divider shared by all axes; unaffected by hold.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    for (genvar k = 0; k < AXES; k++) begin : g_axis
        mouse_quad_axis #(
            .ACC_W (ACC_W),
            .MODE  (MODE)
        ) u_axis (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .pkt     (pkt),
            .flip    (flip_i),
            .tick    (tick),
            .hold    (hold_i),
            .delta   (delta_i[9*k +: 9]),
            .phase   (phase_o[2*k +: 2]),
            .busy    (busy_o[k])
        );
    end

endmodule

// File: tb/tb_mouse_quad_emu.sv
// Directed bench: a 2-axis DIV=1 dir/clk instance (ACC_W=10) and a 1-axis DIV=4 quadrature instance.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: none; step counts are observed through clk-bit toggles of axis 0.
module tb_mouse_quad_emu;

    logic        clk_sys = 1'b0;
    logic        reset_n;

    logic        pkt0, flip0, hold0;
    logic [17:0] delta0;
    logic [3:0]  phase0;
    logic [1:0]  busy0;

    logic        pkt1, flip1, hold1;
    logic [8:0]  delta1;
    logic [1:0]  phase1;
    logic [0:0]  busy1;

    int checks = 0;
    int errors = 0;
    int tog_cnt = 0;
    int base;
    int n;

    always #5 clk_sys = ~clk_sys;

    mouse_quad_emu #(.AXES(2), .ACC_W(10), .DIV(1), .MODE(0)) u_dut0 (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .pkt_toggle_i (pkt0),
        .delta_i      (delta0),
        .flip_i       (flip0),
        .hold_i       (hold0),
        .phase_o      (phase0),
        .busy_o       (busy0)
    );

    mouse_quad_emu #(.AXES(1), .ACC_W(12), .DIV(4), .MODE(1)) u_dut1 (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .pkt_toggle_i (pkt1),
        .delta_i      (delta1),
        .flip_i       (flip1),
        .hold_i       (hold1),
        .phase_o      (phase1),
        .busy_o       (busy1)
    );

    // Each change of axis-0 clk bit on the dir/clk instance is one step.
    always @(phase0[0]) tog_cnt = tog_cnt + 1;

    task automatic cyc(input int k);
        repeat (k) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pkt0 = 1'b0; flip0 = 1'b0; hold0 = 1'b0; delta0 = '0;
        pkt1 = 1'b0; flip1 = 1'b0; hold1 = 1'b0; delta1 = '0;
        cyc(2);
        chk("rst_phase0", 32'(phase0), 32'h0);
        chk("rst_busy0",  32'(busy0),  32'h0);
        chk("rst_phase1", 32'(phase1), 32'h0);
        reset_n = 1'b1;
        cyc(2);

        // +5 on axis 0, -3 on axis 1, stepping every cycle.
        delta0 = {9'h1FD, 9'h005};
        pkt0 = ~pkt0;
        base = tog_cnt;
        cyc(1);
        chk("t1_busy_after_pkt", 32'(busy0), 32'h3);
        chk("t1_no_step_on_pkt", 32'(phase0), 32'h0);
        cyc(4);
        chk("t1_steps4", tog_cnt - base, 4);
        chk("t1_busy_mid", 32'(busy0[0]), 32'h1);
        cyc(1);
        chk("t1_steps5", tog_cnt - base, 5);
        chk("t1_busy_fall", 32'(busy0), 32'h0);
        chk("t1_phase", 32'(phase0), 32'h7);
        cyc(3);
        chk("t1_no_extra", tog_cnt - base, 5);

        // -256 flipped becomes +256; delta/flip only valid on the packet cycle.
        delta0 = {9'h000, 9'h100};
        flip0 = 1'b1;
        pkt0 = ~pkt0;
        base = tog_cnt;
        cyc(1);
        chk("t2_busy", 32'(busy0), 32'h1);
        flip0 = 1'b0;
        delta0 = '0;
        cyc(255);
        chk("t2_steps255", tog_cnt - base, 255);
        chk("t2_busy_mid", 32'(busy0), 32'h1);
        cyc(1);
        chk("t2_steps256", tog_cnt - base, 256);
        chk("t2_busy_fall", 32'(busy0), 32'h0);
        chk("t2_dir_pos", 32'(phase0[1]), 32'h1);

        delta0 = {9'h000, 9'h1FD};
        pkt0 = ~pkt0;
        base = tog_cnt;
        cyc(4);
        chk("t2_neg_steps", tog_cnt - base, 3);
        chk("t2_dir_neg", 32'(phase0[1]), 32'h0);
        chk("t2_neg_idle", 32'(busy0), 32'h0);
        cyc(5);
        chk("t2_dir_held", 32'(phase0[1]), 32'h0);

        // Three back-to-back +255 packets under hold clamp at 511.
        hold0 = 1'b1;
        delta0 = {9'h000, 9'h0FF};
        pkt0 = ~pkt0;
        cyc(1);
        pkt0 = ~pkt0;
        cyc(1);
        pkt0 = ~pkt0;
        cyc(1);
        delta0 = '0;
        base = tog_cnt;
        cyc(2);
        chk("t3_hold_no_steps", tog_cnt - base, 0);
        chk("t3_hold_busy", 32'(busy0), 32'h1);
        hold0 = 1'b0;
        cyc(510);
        chk("t3_steps510", tog_cnt - base, 510);
        chk("t3_busy510", 32'(busy0), 32'h1);
        cyc(1);
        chk("t3_steps511", tog_cnt - base, 511);
        chk("t3_sat_drained", 32'(busy0), 32'h0);

        // acc=+3, then -10 arrives on a stepping cycle: +3-10-1 = -8.
        hold0 = 1'b1;
        delta0 = {9'h000, 9'h003};
        pkt0 = ~pkt0;
        cyc(1);
        hold0 = 1'b0;
        delta0 = {9'h000, 9'h1F6};
        pkt0 = ~pkt0;
        base = tog_cnt;
        cyc(1);
        chk("t4_first_step", tog_cnt - base, 1);
        chk("t4_first_dir_pos", 32'(phase0[1]), 32'h1);
        cyc(1);
        chk("t4_second_dir_neg", 32'(phase0[1]), 32'h0);
        cyc(6);
        chk("t4_steps8", tog_cnt - base, 8);
        chk("t4_busy8", 32'(busy0), 32'h1);
        cyc(1);
        chk("t4_steps9", tog_cnt - base, 9);
        chk("t4_idle", 32'(busy0), 32'h0);

        // Quadrature, DIV=4: +2 then -2.
        delta1 = 9'h002;
        pkt1 = ~pkt1;
        cyc(1);
        chk("q_busy", 32'(busy1), 32'h1);
        chk("q_no_step_on_pkt", 32'(phase1), 32'h0);
        n = 0;
        while (phase1 == 2'b00 && n < 8) begin cyc(1); n++; end
        chk("q_p1", 32'(phase1), 32'h1);
        n = 0;
        while (phase1 == 2'b01 && n < 8) begin cyc(1); n++; end
        chk("q_spacing_pos", n, 4);
        chk("q_p2", 32'(phase1), 32'h3);
        chk("q_idle_pos", 32'(busy1), 32'h0);
        delta1 = 9'h1FE;
        pkt1 = ~pkt1;
        cyc(1);
        chk("q_hold_phase", 32'(phase1), 32'h3);
        n = 0;
        while (phase1 == 2'b11 && n < 8) begin cyc(1); n++; end
        chk("q_n1", 32'(phase1), 32'h1);
        n = 0;
        while (phase1 == 2'b01 && n < 8) begin cyc(1); n++; end
        chk("q_spacing_neg", n, 4);
        chk("q_n2", 32'(phase1), 32'h0);
        chk("q_idle_neg", 32'(busy1), 32'h0);

        // Reset with acc=40 held: everything clears, nothing steps afterwards.
        hold0 = 1'b1;
        delta0 = {9'h000, 9'd40};
        pkt0 = ~pkt0;
        cyc(3);
        chk("r_busy_before", 32'(busy0), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_phase0", 32'(phase0), 32'h0);
        chk("r_busy0", 32'(busy0), 32'h0);
        pkt0 = 1'b0;
        hold0 = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        base = tog_cnt;
        cyc(10);
        chk("r_no_steps", tog_cnt - base, 0);
        chk("r_busy_after", 32'(busy0), 32'h0);
        chk("r_phase_after", 32'(phase0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
